// File: rtl/pim_pkg.sv
// rtl/pim_pkg.sv - shared types, widths and plane weighting for the PIM datapath
package pim_pkg;

    localparam int MAX_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } acc_state_e;

    function automatic int psum_width(input int k);
        return $clog2(k * k + 1);
    endfunction

    // Two's-complement negation of a plane term; used for the MSB plane of signed activations.
    function automatic logic [MAX_W-1:0] msb_weight(input logic [MAX_W-1:0] t, input logic neg);
        return neg ? (~t + 1'b1) : t;
    endfunction

endpackage

// File: rtl/bitplane_term.sv
// rtl/bitplane_term.sv - shifts a plane popcount into place, negating the signed MSB plane
module bitplane_term
    import pim_pkg::*;
#(
    parameter int PSUM_W   = 4,
    parameter int ACT_BITS = 4,
    parameter int OUT_W    = PSUM_W + ACT_BITS,
    parameter bit SIGNED   = 1'b0,
    parameter int CNT_W    = $clog2(ACT_BITS)
) (
    input  logic [PSUM_W-1:0] psum_i,
    input  logic [CNT_W-1:0]  plane_i,
    output logic [OUT_W-1:0]  term_o
);

    localparam logic [CNT_W-1:0] LAST_PLANE = CNT_W'(ACT_BITS - 1);

    logic [OUT_W-1:0] shifted;
    logic [MAX_W-1:0] weighted;
    logic             negate;

    assign shifted  = {{(OUT_W-PSUM_W){1'b0}}, psum_i} << plane_i;
    assign negate   = SIGNED && (plane_i == LAST_PLANE);
    assign weighted = msb_weight(MAX_W'(shifted), negate);
    assign term_o   = weighted[OUT_W-1:0];

endmodule

// File: rtl/bitplane_accumulator.sv
// rtl/bitplane_accumulator.sv - shift-accumulates ACT_BITS popcount planes into one dot-product result
module bitplane_accumulator
    import pim_pkg::*;
#(
    parameter int  kernal   = 3,
    parameter int  ACT_BITS = 4,
    parameter bit  SIGNED   = 1'b0,
    localparam int PSUM_W   = psum_width(kernal),
    localparam int OUT_W    = PSUM_W + ACT_BITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PSUM_W-1:0] psum_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  acc_out
);

    localparam int               CNT_W      = $clog2(ACT_BITS);
    localparam logic [CNT_W-1:0] LAST_PLANE = CNT_W'(ACT_BITS - 1);

    acc_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [OUT_W-1:0] acc_q;
    logic [OUT_W-1:0] acc_out_q;
    logic             out_valid_q;

    logic [OUT_W-1:0] term;
    logic [OUT_W-1:0] acc_sum_d;
    logic             accept;

    bitplane_term #(
        .PSUM_W   (PSUM_W),
        .ACT_BITS (ACT_BITS),
        .OUT_W    (OUT_W),
        .SIGNED   (SIGNED),
        .CNT_W    (CNT_W)
    ) u_term (
        .psum_i  (psum_in),
        .plane_i (cnt_q),
        .term_o  (term)
    );

    // cnt_q is zero in IDLE and HOLD, so the shared term is always the right plane weight.
    assign in_ready  = (state_q != HOLD) || out_ready;
    assign accept    = in_valid && in_ready;
    assign acc_sum_d = acc_q + term;
    assign out_valid = out_valid_q;
    assign acc_out   = acc_out_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            acc_out_q   <= '0;
            out_valid_q <= 1'b0;
        end else if (clr) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        acc_q   <= term;
                        cnt_q   <= CNT_W'(1);
                        state_q <= ACC;
                    end
                end
                ACC: begin
                    if (accept) begin
                        if (cnt_q == LAST_PLANE) begin
                            acc_out_q   <= acc_sum_d;
                            out_valid_q <= 1'b1;
                            cnt_q       <= '0;
                            state_q     <= HOLD;
                        end else begin
                            acc_q <= acc_sum_d;
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (accept) begin
                            acc_q   <= term;
                            cnt_q   <= CNT_W'(1);
                            state_q <= ACC;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
